// File: rtl/fifo_pattern_reader_if.sv
// fifo_pattern_reader_if: FIFO read port plus control/status bundle for the pattern reader
interface fifo_pattern_reader_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
);
  logic                 run;
  logic                 clr_stats;
  logic                 rd_req;
  logic                 rd_empty;
  logic [WIDTH-1:0]     rd_dat;
  logic                 locked;
  logic                 err;
  logic [CNT_WIDTH-1:0] err_cnt;
  logic [CNT_WIDTH-1:0] word_cnt;
  modport master (
    input  run, clr_stats, rd_empty, rd_dat,
    output rd_req, locked, err, err_cnt, word_cnt
  );
  modport slave (
    output run, clr_stats, rd_empty, rd_dat,
    input  rd_req, locked, err, err_cnt, word_cnt
  );
endinterface

// File: rtl/fifo_pattern_reader.sv
// fifo_pattern_reader: drains a FIFO read port and checks words against an incrementing pattern
module fifo_pattern_reader #(
  parameter int               WIDTH      = 8,
  parameter int               CNT_WIDTH  = 16,
  parameter logic [WIDTH-1:0] INC        = 1,
  parameter logic [WIDTH-1:0] SEED       = 0,
  parameter bit               SYNC_MODE  = 0,
  parameter int               LOSS_LIMIT = 4
) (
  input logic                   clk,
  input logic                   aclr,
  fifo_pattern_reader_if.master bus
);
  typedef enum logic {HUNT, LOCK} state_t;
  localparam state_t RST_STATE = SYNC_MODE ? HUNT : LOCK;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  state_t               state_q;
  logic                 vld_q, err_q, err_d, hit, bad, lost;
  logic [WIDTH-1:0]     exp_q;
  logic [7:0]           miss_q, miss_inc;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d, word_cnt_q, word_cnt_d;
  assign bus.rd_req   = bus.run & !bus.rd_empty;
  assign bus.locked   = state_q == LOCK;
  assign bus.err      = err_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.word_cnt = word_cnt_q;
  // compare result and saturating statistics, with clr_stats overriding any increment
  always_comb begin
    hit        = bus.rd_dat == exp_q;
    bad        = vld_q && state_q == LOCK && !hit;
    miss_inc   = miss_q + 8'd1;
    lost       = SYNC_MODE && bad && miss_inc == 8'(LOSS_LIMIT);
    err_d      = !bus.clr_stats && (err_q || bad);
    err_cnt_d  = bus.clr_stats ? '0 : bad && err_cnt_q != CNT_MAX ? err_cnt_q + 1'b1 : err_cnt_q;
    word_cnt_d = bus.clr_stats ? '0 : vld_q && word_cnt_q != CNT_MAX ? word_cnt_q + 1'b1 : word_cnt_q;
  end
  // HUNT/LOCK tracker: the edge after an accepted read compares rd_dat against the expected stream
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q    <= RST_STATE;
      exp_q      <= SEED;
      miss_q     <= '0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      vld_q      <= bus.rd_req;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
      if (vld_q && state_q == HUNT) begin
        exp_q   <= bus.rd_dat + INC;
        miss_q  <= '0;
        state_q <= LOCK;
      end else if (vld_q) begin
        exp_q   <= exp_q + INC;
        miss_q  <= hit || lost ? '0 : miss_inc;
        state_q <= lost ? HUNT : LOCK;
      end
    end
  end
endmodule

// File: doc/fifo_pattern_reader.md
# fifo_pattern_reader

Read-side traffic agent for dual-clock FIFO stress benches. It drains a FIFO read port whenever enabled and data is available, and regenerates the expected incrementing test stream locally. Each returned word is compared against that stream, with sticky error, error-count, word-count and lock status outputs. It sits in the read clock domain, opposite the pattern writer on the write port. It replaces per-bench ad-hoc read checkers.

## Interface
Parameters:
- WIDTH, 8, data width of the FIFO read port.
- CNT_WIDTH, 16, width of err_cnt and word_cnt.
- INC, 1, pattern step; expected value advances by INC mod 2^WIDTH per word.
- SEED, 0, first expected value after reset when SYNC_MODE=0.
- SYNC_MODE, 0, selects how the expected stream starts:
  - 0: expected stream starts at SEED.
  - 1: locks onto the first received word and relocks after loss.
- LOSS_LIMIT, 4, consecutive mismatches that drop lock (SYNC_MODE=1 only); legal range 1..255.

Ports:
- clk  in  1  read-domain clock, all logic on posedge.
- aclr  in  1  asynchronous reset, active-high.
- run  in  1  permits issuing reads.
- clr_stats  in  1  synchronous clear of err, err_cnt, word_cnt.
- rd_req  out  1  FIFO read request, combinational: run & !rd_empty.
- rd_empty  in  1  FIFO empty flag.
- rd_dat  in  WIDTH  FIFO read data, valid on the edge after an accepted read.
- locked  out  1  high in LOCK state.
- err  out  1  sticky mismatch flag.
- err_cnt  out  CNT_WIDTH  mismatch count, saturating at all-ones.
- word_cnt  out  CNT_WIDTH  checked-word count, saturating at all-ones.

## Operation
- A read is accepted on the posedge where rd_req & !rd_empty. A registered vld flag marks the following edge as the compare edge for rd_dat.
- States are HUNT and LOCK. Reset state is LOCK with exp=SEED when SYNC_MODE=0, and HUNT when SYNC_MODE=1.
- HUNT, on a compare edge with word w:
  - exp <= w+INC; miss_run <= 0.
  - Go to LOCK; word_cnt increments; no error recorded.
- LOCK, on a compare edge with word w:
  - word_cnt increments; exp <= exp+INC regardless of the compare result.
  - If w==exp: miss_run <= 0.
  - If w!=exp: err <= 1; err_cnt increments; miss_run increments.
  - If SYNC_MODE=1 and the mismatch makes miss_run reach LOSS_LIMIT: go to HUNT; miss_run <= 0.
  - With SYNC_MODE=0 the block never leaves LOCK.
- All arithmetic is mod 2^WIDTH, so exp wraps 0xFF -> 0x00 at WIDTH=8. Counters hold at all-ones and never wrap.
- clr_stats clears err, err_cnt and word_cnt on that edge and takes priority over any increment on the same edge. State, exp and miss_run are unaffected.
- Deasserting run stops new reads only. A word already accepted is still compared on the next edge.

## Timing
- Reset values: rd_req follows run & !rd_empty. err=0, err_cnt=0, word_cnt=0, miss_run=0, vld=0. locked=1 when SYNC_MODE=0 and 0 when SYNC_MODE=1.
- aclr acts immediately and asynchronously. A read accepted just before aclr is discarded and never counted.
- Accept at edge k gives the compare at edge k+1. err, err_cnt, word_cnt and locked update at the output of edge k+1.
- Back-to-back accepts give one compare per cycle with no bubbles; throughput is 1 word/clk.
- rd_req has zero latency from rd_empty and run. No other path from an input to an output is combinational.

## Test plan
- SYNC_MODE=0, SEED=0: feed words 0..20 with rd_empty toggling randomly -> word_cnt=21, err_cnt=0, err=0, locked=1 throughout.
- SYNC_MODE=0: feed 0..4, 0x55, 6..9 -> err rises and err_cnt=1 on the compare edge of 0x55. Words 6..9 pass, final word_cnt=10.
- SYNC_MODE=1: first word 0x40, then 0x41..0x4F -> locked rises on the first compare edge, err_cnt=0, word_cnt=16. With INC=1, exp=0xFF is followed by 0x00 without error.
- SYNC_MODE=1, LOSS_LIMIT=4: in LOCK, 4 consecutive bad words -> locked falls on the 4th compare edge with err_cnt=4. Next word 0x90 relocks and 0x91 passes.
- CNT_WIDTH=4: 20 mismatches -> err_cnt holds 15. Pulse clr_stats on an edge that is also a mismatch edge -> err=0, err_cnt=0, word_cnt=0 after that edge.
- Assert aclr the cycle after an accepted read -> all counters 0 immediately, pending word not counted. After release (SYNC_MODE=0) the next word must equal SEED.
